vproc_bus_responder: RTL
========================

Name: vproc_bus_responder

Overview:
- Target-side partner of the VProc virtual processor bus.
- Accepts VProc write/read commands (Addr, WE, RD, DataOut) and completes them with WRAck/RDAck pulses after a programmable number of wait states.
- Serves a word-addressed RAM plus a small register bank (interrupt request register, countdown timer). Drives the 3-bit Interrupt input back to VProc and closes the Update/UpdateResponse delta handshake.
- Sits in the test harness between one VProc node and the model under test.

Parameters:
- ADDR_BITS, 10, RAM word-address width; depth is 2**ADDR_BITS words.
- WAIT_STATES, 0, extra cycles inserted before each ack (0..255).
- REG_BASE, 32'hAFFF_0000, base of register region; match on Addr[31:16].
- DEFAULT_DATA, 32'hDEAD_BEEF, DataIn value for unmapped reads.

Ports:
- Clk  input  1  bus clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Addr  input  32  byte address from VProc.
- WE  input  1  write request level.
- RD  input  1  read request level.
- DataOut  input  32  write data from VProc.
- DataIn  output  32  read data to VProc.
- WRAck  output  1  write-complete pulse.
- RDAck  output  1  read-complete pulse.
- Interrupt  output  3  interrupt vector to VProc.
- Update  input  1  VProc update toggle.
- UpdateResponse  output  1  update acknowledge.

Behaviour:
- Reset (nReset low, async): WRAck=0, RDAck=0, DataIn=0, Interrupt=0, timer=0, FSM=IDLE, wait counter=0. RAM contents are not reset. Outputs stay at these values while nReset is low.
- UpdateResponse is a purely combinational copy of Update (zero-time echo). It is never registered, so VProc's wait on UpdateResponse cannot straddle a clock edge.
- All other logic is sampled on posedge Clk.
- FSM IDLE:
  - WE=1 (WE has priority if RD is also 1): go to WAIT with count=WAIT_STATES, or go directly to ACK if WAIT_STATES=0.
  - RD=1 (WE=0): same path as WE.
  - Otherwise stay in IDLE.
- FSM WAIT: decrement count each cycle; when count reaches 1, go to ACK.
- Entering ACK:
  - For a write, commit DataOut to RAM or register.
  - For a read, register the read data onto DataIn.
  - Assert the matching ack (WRAck or RDAck) for exactly one cycle.
- FSM ACK: unconditionally return to IDLE next edge. The command level seen at this edge belongs to the already-acked transfer and is ignored. Back-to-back commands therefore cost WAIT_STATES+2 cycles per transfer.
- Ack latency: command first sampled at edge N; ack high in the cycle after edge N+WAIT_STATES.
- DataIn holds its last value outside ACK.
- Decode:
  - Addr[31:16]==REG_BASE[31:16]: register space.
  - Else Addr[31:ADDR_BITS+2]==0: RAM at word Addr[ADDR_BITS+1:2]; Addr[1:0] ignored.
  - Else unmapped: writes dropped but still acked; reads return DEFAULT_DATA.
- Registers (offset Addr[7:0]; other offsets read 0, writes ignored):
  - 0x00 INT: RW; bits[2:0] drive Interrupt directly. Writes replace the value.
  - 0x04 TIMER: RW; 32-bit countdown.
- Timer:
  - Nonzero TIMER decrements by 1 every cycle.
  - The transition 1->0 sets INT[0]. It fires once and does not reload.
  - Writing 0 stops the timer.
- Simultaneous events:
  - Timer expiry in the same cycle as an INT write: written value lands, then INT[0] is forced to 1 (set wins).
  - TIMER write in the same cycle as the decrement: written value wins.
- Reset mid-transfer: FSM aborts to IDLE with no ack. An in-flight write is not committed. VProc must re-drive the command after reset.

Optional Feature:
- Macro: VPROC_RESP_TIMER_EN.
- Defined: TIMER register and expiry interrupt exist as above.
- Undefined: no timer logic; offset 0x04 reads 0, writes are ignored; INT[0] changes only by software write.

Test Plan:
- WAIT_STATES=0: write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 -> WRAck one-cycle pulse 1 cycle after command; RDAck pulse with DataIn=0x1234_5678; each transfer takes 2 cycles.
- WAIT_STATES=3: back-to-back reads of 0x0, 0x4 (RD held high) -> each RDAck exactly 4 cycles after command sample; no duplicate ack; 5 cycles per transfer.
- Read 0x8000_0000 -> RDAck with DataIn=0xDEAD_BEEF. Write to the same address -> WRAck; RAM unchanged.
- Write INT=3'b101 -> Interrupt=5 the cycle after ack. Write INT=0 -> Interrupt=0.
- With VPROC_RESP_TIMER_EN: write TIMER=10 -> Interrupt[0]=1 exactly 10 cycles after the commit edge. INT write of 3'b100 on the expiry edge -> Interrupt=3'b101.
- Assert nReset during WAIT of a write to 0x20 -> no WRAck; all outputs 0; subsequent read of 0x20 returns prior contents. Toggle Update any time -> UpdateResponse follows in zero time.

Source files
------------

// File: rtl/vproc_bus_responder_if.sv
// VProc bus bundle between one VProc node (master) and its target-side
// responder (slave).
//   Addr, WE, RD, DataOut : command from VProc (byte address, levels, write data)
//   DataIn                : read data returned to VProc
//   WRAck, RDAck          : one-cycle completion pulses
//   Interrupt             : 3-bit interrupt vector back to VProc
//   Update/UpdateResponse : delta-cycle update handshake
interface vproc_bus_responder_if;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        WRAck;
    logic        RDAck;
    logic [2:0]  Interrupt;
    logic        Update;
    logic        UpdateResponse;

    modport master (
        output Addr, WE, RD, DataOut, Update,
        input  DataIn, WRAck, RDAck, Interrupt, UpdateResponse
    );

    modport slave (
        input  Addr, WE, RD, DataOut, Update,
        output DataIn, WRAck, RDAck, Interrupt, UpdateResponse
    );
endinterface

// File: rtl/vproc_bus_responder.sv
// Target-side responder for the VProc virtual processor bus.
// Completes VProc write/read commands after WAIT_STATES extra cycles with a
// one-cycle WRAck/RDAck pulse. Serves a word-addressed RAM, an INT register
// (drives Interrupt) and, when VPROC_RESP_TIMER_EN is defined, a 32-bit
// countdown timer whose 1->0 transition sets INT[0].
// Ports:
//   Clk     : bus clock, rising edge
//   nReset  : asynchronous active-low reset
//   bus     : vproc_bus_responder_if.slave (Addr, WE, RD, DataOut, DataIn,
//             WRAck, RDAck, Interrupt, Update, UpdateResponse)
// Build option: define VPROC_RESP_TIMER_EN to include the TIMER register.
module vproc_bus_responder #(
    parameter int          ADDR_BITS    = 10,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] REG_BASE     = 32'hAFFF_0000,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEAD_BEEF
) (
    input  logic                  Clk,
    input  logic                  nReset,
    vproc_bus_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_STATES);
    localparam logic [15:0] REG_PAGE  = REG_BASE[31:16];

    state_t                 state_r;
    state_t                 state_s;
    logic [7:0]             count_r;
    logic [7:0]             count_s;
    logic                   is_write_r;
    logic                   is_write_s;
    logic                   fire_s;        // this edge enters ACK
    logic                   fire_write_s;  // the transfer entering ACK is a write

    logic                   sel_reg_s;
    logic                   sel_ram_s;
    logic [7:0]             reg_off_s;
    logic [ADDR_BITS-1:0]   ram_idx_s;
    logic                   wr_commit_s;
    logic                   ram_we_s;
    logic                   int_we_s;
    logic                   expire_s;
    logic [31:0]            rdata_s;

    logic [31:0]            ram_r [2**ADDR_BITS];
    logic [2:0]             int_r;
    logic [2:0]             int_next_s;
    logic [31:0]            data_in_r;
    logic                   wr_ack_r;
    logic                   rd_ack_r;

    // Address decode: register page first, then RAM window, else unmapped.
    assign reg_off_s   = bus.Addr[7:0];
    assign ram_idx_s   = bus.Addr[ADDR_BITS+1:2];
    assign sel_reg_s   = (bus.Addr[31:16] == REG_PAGE);
    assign sel_ram_s   = !sel_reg_s && ((bus.Addr >> (ADDR_BITS + 2)) == 32'd0);

    assign wr_commit_s = fire_s && fire_write_s;
    assign ram_we_s    = wr_commit_s && sel_ram_s;
    assign int_we_s    = wr_commit_s && sel_reg_s && (reg_off_s == 8'h00);

    // FSM state register; reset aborts any in-flight transfer without an ack.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r    <= ST_IDLE;
            count_r    <= 8'd0;
            is_write_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            is_write_r <= is_write_s;
        end
    end

    // FSM next state: IDLE samples the command (WE wins over RD), WAIT counts
    // down, ACK always returns to IDLE so the still-held command level is ignored.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        is_write_s   = is_write_r;
        fire_s       = 1'b0;
        fire_write_s = is_write_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.WE || bus.RD) begin
                    is_write_s   = bus.WE;
                    fire_write_s = bus.WE;
                    if (WAIT_INIT == 8'd0) begin
                        state_s = ST_ACK;
                        count_s = 8'd0;
                        fire_s  = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        count_s = WAIT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r <= 8'd1) begin
                    state_s = ST_ACK;
                    count_s = 8'd0;
                    fire_s  = 1'b1;
                end else begin
                    count_s = count_r - 8'd1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = 8'd0;
            end
        endcase
    end

`ifdef VPROC_RESP_TIMER_EN
    logic [31:0] timer_r;
    logic        timer_we_s;

    assign timer_we_s = wr_commit_s && sel_reg_s && (reg_off_s == 8'h04);
    // A TIMER write on the final count replaces the value, so no expiry then.
    assign expire_s   = (timer_r == 32'd1) && !timer_we_s;

    // Countdown timer: a write wins over the decrement, zero stays stopped.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            timer_r <= 32'd0;
        end else if (timer_we_s) begin
            timer_r <= bus.DataOut;
        end else if (timer_r != 32'd0) begin
            timer_r <= timer_r - 32'd1;
        end else begin
            timer_r <= timer_r;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Read data mux for the transfer entering ACK.
    always_comb begin
        rdata_s = DEFAULT_DATA;
        if (sel_reg_s) begin
            case (reg_off_s)
                8'h00:   rdata_s = {29'd0, int_r};
`ifdef VPROC_RESP_TIMER_EN
                8'h04:   rdata_s = timer_r;
`endif
                default: rdata_s = 32'd0;
            endcase
        end else if (sel_ram_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else begin
            rdata_s = DEFAULT_DATA;
        end
    end

    // INT next value: a software write lands first, then timer expiry sets bit 0.
    always_comb begin
        int_next_s    = int_we_s ? bus.DataOut[2:0] : int_r;
        int_next_s[0] = int_next_s[0] | expire_s;
    end

    // INT register; drives Interrupt directly.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            int_r <= 3'd0;
        end else begin
            int_r <= int_next_s;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= bus.DataOut;
        end
    end

    // Registered acks and read data; DataIn holds between reads.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            data_in_r <= 32'd0;
            wr_ack_r  <= 1'b0;
            rd_ack_r  <= 1'b0;
        end else begin
            wr_ack_r <= fire_s && fire_write_s;
            rd_ack_r <= fire_s && !fire_write_s;
            if (fire_s && !fire_write_s) begin
                data_in_r <= rdata_s;
            end
        end
    end

    assign bus.DataIn    = data_in_r;
    assign bus.WRAck     = wr_ack_r;
    assign bus.RDAck     = rd_ack_r;
    assign bus.Interrupt = int_r;
    // Zero-time echo so VProc's update wait never spans a clock edge.
    assign bus.UpdateResponse = bus.Update;

endmodule
